// File: rtl/ssp_rx_rjustify.sv
// SSP receive deserialiser: shifts in frame bits MSB-first and writes one right-justified,
// zero-filled word per frame into the RX FIFO, flagging overrun when the FIFO is full.
module ssp_rx_rjustify #(
  parameter int unsigned DW = 16
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          RxEn,
  input  logic [1:0]    FRFPCLK,
  input  logic [3:0]    DSSPCLK,
  input  logic          MS,
  input  logic          FrameStart,
  input  logic          RxSample,
  input  logic          RxBit,
  input  logic          RxFFull,
  output logic [DW-1:0] RxFWrData,
  output logic          RxFWr,
  output logic          RxOverrun,
  output logic          RxBusy
);

  typedef enum logic [1:0] {
    StIdle,
    StTurn,
    StShift,
    StWrite
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    dss_lat_q, dss_lat_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          ovr_q, ovr_d;

  logic size_ok;
  logic mw_master;

  // Sizes below 4 bits are reserved: the frame is ignored outright.
  assign size_ok   = (DSSPCLK >= 4'd3);
  assign mw_master = (FRFPCLK == 2'b10) && !MS;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dss_lat_d = dss_lat_q;
    shreg_d   = shreg_q;
    wdata_d   = wdata_q;
    wr_d      = 1'b0;
    ovr_d     = 1'b0;

    if (!RxEn) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
      shreg_d = '0;
    end else begin
      // The write decision is taken in WRITE even if a new frame starts in the same cycle.
      if (state_q == StWrite) begin
        if (RxFFull) begin
          ovr_d = 1'b1;
        end else begin
          wr_d    = 1'b1;
          wdata_d = shreg_q;
        end
      end

      if (FrameStart) begin
        // A coincident RxSample is deliberately not captured.
        dss_lat_d = DSSPCLK;
        cnt_d     = 4'd0;
        shreg_d   = '0;
        if (!size_ok) begin
          state_d = StIdle;
        end else if (mw_master) begin
          state_d = StTurn;
        end else begin
          state_d = StShift;
        end
      end else begin
        case (state_q)
          StIdle: begin
            state_d = StIdle;
          end
          StTurn: begin
            // Turnaround bit is consumed without being stored.
            if (RxSample) begin
              state_d = StShift;
            end
          end
          StShift: begin
            if (RxSample) begin
              shreg_d = {shreg_q[DW-2:0], RxBit};
              if (cnt_q == dss_lat_q) begin
                cnt_d   = 4'd0;
                state_d = StWrite;
              end else begin
                cnt_d = cnt_q + 4'd1;
              end
            end
          end
          StWrite: begin
            state_d = StIdle;
          end
          default: begin
            state_d = StIdle;
          end
        endcase
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      dss_lat_q <= 4'd0;
      shreg_q   <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dss_lat_q <= dss_lat_d;
      shreg_q   <= shreg_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign RxFWrData = wdata_q;
  assign RxFWr     = wr_q;
  assign RxOverrun = ovr_q;
  assign RxBusy    = (state_q != StIdle);

endmodule

// File: tb/tb_ssp_rx_rjustify.sv
// Directed bench for ssp_rx_rjustify: hand-computed frames checked with immediate assertions.
module tb_ssp_rx_rjustify;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        RxEn = 1'b0;
  logic [1:0]  FRFPCLK = 2'b00;
  logic [3:0]  DSSPCLK = 4'd0;
  logic        MS = 1'b0;
  logic        FrameStart = 1'b0;
  logic        RxSample = 1'b0;
  logic        RxBit = 1'b0;
  logic        RxFFull = 1'b0;
  logic [15:0] RxFWrData;
  logic        RxFWr;
  logic        RxOverrun;
  logic        RxBusy;

  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;
  int wr_before;

  ssp_rx_rjustify dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .RxEn       (RxEn),
    .FRFPCLK    (FRFPCLK),
    .DSSPCLK    (DSSPCLK),
    .MS         (MS),
    .FrameStart (FrameStart),
    .RxSample   (RxSample),
    .RxBit      (RxBit),
    .RxFFull    (RxFFull),
    .RxFWrData  (RxFWrData),
    .RxFWr      (RxFWr),
    .RxOverrun  (RxOverrun),
    .RxBusy     (RxBusy)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    if (RxFWr === 1'b1) wr_count <= wr_count + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    @(negedge PCLK);
    FrameStart = 1'b1;
    @(negedge PCLK);
    FrameStart = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge PCLK);
      RxSample = 1'b1;
      RxBit    = v[i];
      @(negedge PCLK);
      RxSample = 1'b0;
    end
  endtask

  // Called at the negedge inside the WRITE cycle.
  task automatic expect_write(input string tag, input logic [15:0] exp);
    check({tag, "_early"}, {15'd0, RxFWr}, 16'd0);
    @(negedge PCLK);
    check({tag, "_wr"}, {15'd0, RxFWr}, 16'd1);
    check({tag, "_data"}, RxFWrData, exp);
    check({tag, "_ovr"}, {15'd0, RxOverrun}, 16'd0);
    @(negedge PCLK);
    check({tag, "_wr_pulse"}, {15'd0, RxFWr}, 16'd0);
  endtask

  initial begin
    // Reset
    @(negedge PCLK);
    @(negedge PCLK);
    check("rst_data", RxFWrData, 16'h0000);
    check("rst_wr", {15'd0, RxFWr}, 16'd0);
    check("rst_ovr", {15'd0, RxOverrun}, 16'd0);
    check("rst_busy", {15'd0, RxBusy}, 16'd0);
    PRESETn = 1'b1;
    RxEn    = 1'b1;

    // 4-bit Motorola frame 1011
    DSSPCLK = 4'd3;
    start_frame();
    check("t1_busy", {15'd0, RxBusy}, 16'd1);
    send_bits(16'h000B, 4);
    expect_write("t1", 16'h000B);

    // 16-bit frame
    DSSPCLK = 4'd15;
    start_frame();
    send_bits(16'hA5C3, 16);
    expect_write("t2", 16'hA5C3);

    // Microwire master: dummy bit 1 then 0x3C
    FRFPCLK = 2'b10;
    MS      = 1'b0;
    DSSPCLK = 4'd7;
    start_frame();
    send_bits(16'h013C, 9);
    expect_write("t3", 16'h003C);

    // Overrun: FIFO full at write time
    FRFPCLK = 2'b00;
    RxFFull = 1'b1;
    start_frame();
    send_bits(16'h0055, 8);
    check("t4_ovr_early", {15'd0, RxOverrun}, 16'd0);
    @(negedge PCLK);
    check("t4_wr", {15'd0, RxFWr}, 16'd0);
    check("t4_ovr", {15'd0, RxOverrun}, 16'd1);
    check("t4_data", RxFWrData, 16'h003C);
    @(negedge PCLK);
    check("t4_ovr_pulse", {15'd0, RxOverrun}, 16'd0);
    RxFFull = 1'b0;

    // FrameStart after 5 of 8 bits restarts the frame
    wr_before = wr_count;
    start_frame();
    send_bits(16'h0016, 5);
    start_frame();
    send_bits(16'h0081, 8);
    expect_write("t5", 16'h0081);
    check("t5_count", 16'(wr_count - wr_before), 16'd1);

    // RxEn low mid-frame aborts without a write
    wr_before = wr_count;
    start_frame();
    send_bits(16'h0007, 3);
    @(negedge PCLK);
    RxEn = 1'b0;
    @(negedge PCLK);
    check("t6_busy", {15'd0, RxBusy}, 16'd0);
    RxEn = 1'b1;
    send_bits(16'h001F, 5);
    @(negedge PCLK);
    @(negedge PCLK);
    check("t6_count", 16'(wr_count - wr_before), 16'd0);
    check("t6_data", RxFWrData, 16'h0081);

    // Reserved size: no frame
    wr_before = wr_count;
    DSSPCLK = 4'd2;
    start_frame();
    check("t7_busy", {15'd0, RxBusy}, 16'd0);
    send_bits(16'h0005, 3);
    @(negedge PCLK);
    @(negedge PCLK);
    check("t7_count", 16'(wr_count - wr_before), 16'd0);
    check("t7_ovr", {15'd0, RxOverrun}, 16'd0);

    // Back-to-back frames: FrameStart in WRITE; mid-frame DSS change ignored
    DSSPCLK = 4'd3;
    start_frame();
    send_bits(16'h0009, 4);
    FrameStart = 1'b1;
    @(negedge PCLK);
    FrameStart = 1'b0;
    check("t8_wr", {15'd0, RxFWr}, 16'd1);
    check("t8_data", RxFWrData, 16'h0009);
    check("t8_busy", {15'd0, RxBusy}, 16'd1);
    DSSPCLK = 4'd15;
    send_bits(16'h0006, 4);
    expect_write("t8b", 16'h0006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
